// File: rtl/ov7670_capture_pkg.sv
// Shared OV7670 capture definitions: default frame geometry, FSM state
// encodings and the frame-size helper used by the capture and downstream blocks.
package ov7670_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    WAIT_VS    = 2'd0,
    WAIT_START = 2'd1,
    ACTIVE     = 2'd2
  } cap_state_t;

  function automatic int frame_pixels(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Single register stage for the camera bus plus one-cycle edge pulses
// derived from the registered copy against its previous value.
module cam_sync_edge #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [DATA_W-1:0] cam_d,
  output logic              href_lvl,
  output logic [DATA_W-1:0] data,
  output logic              vsync_rise,
  output logic              vsync_fall,
  output logic              href_fall
);

  logic vsync_s, vsync_p;
  logic href_s, href_p;

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of its source, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s <= 1'b0;
      vsync_p <= 1'b0;
      href_s  <= 1'b0;
      href_p  <= 1'b0;
      data    <= '0;
    end else begin
      vsync_s <= vsync;
      vsync_p <= vsync_s;
      href_s  <= href;
      href_p  <= href_s;
      data    <= cam_d;
    end
  end

  assign href_lvl   = href_s;
  assign vsync_rise = vsync_s & ~vsync_p;
  assign vsync_fall = ~vsync_s & vsync_p;
  assign href_fall  = ~href_s & href_p;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: pairs bus bytes into pixels, generates linear
// frame-buffer write addresses, and flags frame completion and framing errors.
module ov7670_capture
  import ov7670_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        cam_d,
  output logic [15:0]       pixel_data,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_done,
  output logic              capturing,
  output logic              err_odd,
  output logic              err_ovf
);

  localparam int FRAME_PIXELS = frame_pixels(H_ACTIVE, V_ACTIVE);
  // One extra bit so the counter can sit at exactly FRAME_PIXELS when saturated.
  localparam int CNT_W = ADDR_W + 1;

  logic       href_lvl;
  logic [7:0] byte_s;
  logic       vs_rise, vs_fall, href_fall;

  cam_sync_edge #(.DATA_W(8)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .href       (href),
    .cam_d      (cam_d),
    .href_lvl   (href_lvl),
    .data       (byte_s),
    .vsync_rise (vs_rise),
    .vsync_fall (vs_fall),
    .href_fall  (href_fall)
  );

  cap_state_t       state_q, state_d;
  logic             frame_start, frame_end;
  logic             phase;
  logic [7:0]       hi_reg;
  logic [CNT_W-1:0] pix_cnt;
  logic             cnt_full;

  assign cnt_full = (pix_cnt == CNT_W'(FRAME_PIXELS));

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      WAIT_VS: begin
        if (vs_rise) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (vs_fall) begin
          if (enable) begin
            state_d     = ACTIVE;
            frame_start = 1'b1;
          end else begin
            state_d = WAIT_VS;
          end
        end
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_d   = WAIT_START;
          frame_end = 1'b1;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_VS;
    else        state_q <= state_d;
  end

  // NOTE: hi_reg is reset along with the control state; it is a single byte,
  // so a reset costs nothing and keeps pixel_data deterministic after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= 1'b0;
      hi_reg      <= '0;
      pix_cnt     <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      wr_addr     <= '0;
      frame_done  <= 1'b0;
      capturing   <= 1'b0;
      err_odd     <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= frame_end;
      capturing   <= (state_d == ACTIVE);
      if (frame_start) begin
        phase   <= 1'b0;
        pix_cnt <= '0;
        err_odd <= 1'b0;
        err_ovf <= 1'b0;
      end else if (state_q == ACTIVE) begin
        if (href_lvl) begin
          if (!phase) begin
            hi_reg <= byte_s;
            phase  <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (cnt_full) begin
              err_ovf <= 1'b1;
            end else begin
              pixel_data  <= {hi_reg, byte_s};
              wr_addr     <= pix_cnt[ADDR_W-1:0];
              pixel_valid <= 1'b1;
              pix_cnt     <= pix_cnt + 1'b1;
            end
          end
        end else if (href_fall && phase) begin
          phase <= 1'b0;
          if (!vs_rise) err_odd <= 1'b1;
        end
        // Frame end discards any half pixel; a pair completing on this edge
        // was already emitted above.
        if (vs_rise) phase <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a 4x2 frame: reset, full frame,
// enable gating, odd lines, overflow, vsync mid-line and coincident done/pixel.
module tb_ov7670_capture;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          vsync;
  logic          href;
  logic [7:0]    cam_d;
  logic [15:0]   pixel_data;
  logic          pixel_valid;
  logic [AW-1:0] wr_addr;
  logic          frame_done;
  logic          capturing;
  logic          err_odd;
  logic          err_ovf;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .vsync       (vsync),
    .href        (href),
    .cam_d       (cam_d),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .wr_addr     (wr_addr),
    .frame_done  (frame_done),
    .capturing   (capturing),
    .err_odd     (err_odd),
    .err_ovf     (err_ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int b1_cyc;

  logic [15:0]   pix_data_q[$];
  logic [AW-1:0] pix_addr_q[$];
  int            pix_cyc_q[$];
  int            fd_cnt;
  int            fd_cyc;
  logic [7:0]    tx[16];

  always @(posedge clk) cyc++;

  // Passive monitor, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (pixel_valid) begin
      pix_data_q.push_back(pixel_data);
      pix_addr_q.push_back(wr_addr);
      pix_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic clear_mon();
    pix_data_q.delete();
    pix_addr_q.delete();
    pix_cyc_q.delete();
    fd_cnt = 0;
    fd_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 16; i++) tx[i] = base + 8'(i);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      href  = 1'b1;
      cam_d = tx[i];
      if (i == 1) b1_cyc = cyc;
    end
    @(negedge clk);
    href = 1'b0;
    idle(4);
  endtask

  task automatic vs_high();
    @(negedge clk);
    vsync = 1'b1;
    href  = 1'b0;
    idle(4);
  endtask

  task automatic vs_low();
    @(negedge clk);
    vsync = 1'b0;
    idle(4);
  endtask

  task automatic check_outputs_zero(input string tag);
    total++;
    if ({pixel_data, pixel_valid, wr_addr, frame_done, capturing, err_odd, err_ovf} !== '0) begin
      bad++;
      $display("FAIL %s outputs got data=%h pv=%b addr=%0d fd=%b cap=%b eo=%b ev=%b want all 0",
               tag, pixel_data, pixel_valid, wr_addr, frame_done, capturing, err_odd, err_ovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; vsync = 1'b0; href = 1'b0; cam_d = 8'h00;
    idle(3);
    #1 check_outputs_zero("reset_initial");
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    check_outputs_zero("reset_released");
    // Get into ACTIVE with an odd line so flags and data are non-zero.
    vs_high();
    vs_low();
    fill(8'hA1);
    send_line(5);
    total++;
    if (capturing !== 1'b1 || err_odd !== 1'b1 || pixel_data !== 16'hA3A4) begin
      bad++;
      $display("FAIL reset_precond got cap=%b eo=%b data=%h want 1 1 a3a4", capturing, err_odd, pixel_data);
    end
    @(negedge clk) href = 1'b1; cam_d = 8'h55;
    @(negedge clk) cam_d = 8'h66;
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("reset_async");
    idle(3);
    check_outputs_zero("reset_held");
    rst_n = 1'b1;
    href = 1'b0;
    clear_mon();
    fill(8'h10);
    send_line(8);
    total++;
    if (pix_data_q.size() !== 0 || capturing !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_capture got pixels=%0d cap=%b want 0 0", pix_data_q.size(), capturing);
    end
    vs_high();
    vs_low();
    total++;
    if (capturing !== 1'b1) begin
      bad++;
      $display("FAIL reset_recapture got cap=%b want 1", capturing);
    end
    vs_high();
  endtask

  task automatic test_full_frame();
    int first_b1;
    clear_mon();
    enable = 1'b1;
    vs_low();
    tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h56; tx[3] = 8'h78;
    tx[4] = 8'h9A; tx[5] = 8'hBC; tx[6] = 8'hDE; tx[7] = 8'hF0;
    send_line(8);
    first_b1 = b1_cyc;
    tx[0] = 8'h0F; tx[1] = 8'hED; tx[2] = 8'hCB; tx[3] = 8'hA9;
    tx[4] = 8'h87; tx[5] = 8'h65; tx[6] = 8'h43; tx[7] = 8'h21;
    send_line(8);
    total++;
    if (fd_cnt !== 0) begin
      bad++;
      $display("FAIL full_early_done got=%0d want=0", fd_cnt);
    end
    vs_high();
    total++;
    if (pix_data_q.size() !== 8) begin
      bad++;
      $display("FAIL full_count got=%0d want=8", pix_data_q.size());
    end
    for (int j = 0; j < 8 && j < pix_data_q.size(); j++) begin
      logic [15:0] exp_d;
      case (j)
        0: exp_d = 16'h1234; 1: exp_d = 16'h5678; 2: exp_d = 16'h9ABC; 3: exp_d = 16'hDEF0;
        4: exp_d = 16'h0FED; 5: exp_d = 16'hCBA9; 6: exp_d = 16'h8765; default: exp_d = 16'h4321;
      endcase
      total++;
      if (pix_data_q[j] !== exp_d || pix_addr_q[j] !== AW'(j)) begin
        bad++;
        $display("FAIL full_pixel%0d got data=%h addr=%0d want data=%h addr=%0d",
                 j, pix_data_q[j], pix_addr_q[j], exp_d, j);
      end
    end
    if (pix_cyc_q.size() > 0) begin
      total++;
      if (pix_cyc_q[0] !== first_b1 + 2) begin
        bad++;
        $display("FAIL full_latency got=%0d want=%0d", pix_cyc_q[0] - first_b1, 2);
      end
    end
    total++;
    if (fd_cnt !== 1 || err_odd !== 1'b0 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL full_done got fd=%0d eo=%b ev=%b want 1 0 0", fd_cnt, err_odd, err_ovf);
    end
  endtask

  task automatic test_enable_gating();
    clear_mon();
    enable = 1'b0;
    vs_low();
    fill(8'h20);
    send_line(8);
    enable = 1'b1;
    send_line(8);
    vs_high();
    total++;
    if (pix_data_q.size() !== 0 || fd_cnt !== 0 || capturing !== 1'b0) begin
      bad++;
      $display("FAIL gate_idle got pixels=%0d fd=%0d cap=%b want 0 0 0", pix_data_q.size(), fd_cnt, capturing);
    end
    clear_mon();
    vs_low();
    total++;
    if (capturing !== 1'b1) begin
      bad++;
      $display("FAIL gate_next_frame got cap=%b want 1", capturing);
    end
    fill(8'h30);
    send_line(4);
    vs_high();
    total++;
    if (pix_data_q.size() !== 2 || pix_addr_q[0] !== 3'd0 || pix_data_q[0] !== 16'h3031) begin
      bad++;
      $display("FAIL gate_pixels got n=%0d want n=2 first 3031@0", pix_data_q.size());
    end
  endtask

  task automatic test_odd_line();
    clear_mon();
    vs_low();
    fill(8'h50);
    send_line(7);
    total++;
    if (pix_data_q.size() !== 3 || err_odd !== 1'b1 || pix_addr_q[2] !== 3'd2 || pix_data_q[2] !== 16'h5455) begin
      bad++;
      $display("FAIL odd_line got n=%0d eo=%b want n=3 eo=1 last 5455@2", pix_data_q.size(), err_odd);
    end
    fill(8'h60);
    send_line(4);
    total++;
    if (pix_data_q.size() !== 5 || pix_addr_q[3] !== 3'd3 || pix_data_q[3] !== 16'h6061 || pix_data_q[4] !== 16'h6263) begin
      bad++;
      $display("FAIL odd_next_line got n=%0d want n=5 6061@3 6263@4", pix_data_q.size());
    end
    vs_high();
    total++;
    if (err_odd !== 1'b1 || fd_cnt !== 1) begin
      bad++;
      $display("FAIL odd_sticky got eo=%b fd=%0d want 1 1", err_odd, fd_cnt);
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    vs_low();
    total++;
    if (err_odd !== 1'b0 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_start_clear got eo=%b ev=%b want 0 0", err_odd, err_ovf);
    end
    for (int l = 0; l <= V; l++) begin
      fill(8'h40 + 8'(8 * l));
      send_line(2 * H);
    end
    total++;
    if (pix_data_q.size() !== H * V || err_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_count got n=%0d ev=%b want n=%0d ev=1", pix_data_q.size(), err_ovf, H * V);
    end
    if (pix_data_q.size() > 0) begin
      total++;
      if (pix_addr_q[$] !== AW'(H * V - 1) || pix_data_q[$] !== 16'h4E4F) begin
        bad++;
        $display("FAIL ovf_last got data=%h addr=%0d want 4e4f@%0d", pix_data_q[$], pix_addr_q[$], H * V - 1);
      end
    end
    vs_high();
    clear_mon();
    vs_low();
    total++;
    if (err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b want=0", err_ovf);
    end
    vs_high();
  endtask

  task automatic test_vsync_mid_line();
    clear_mon();
    vs_low();
    @(negedge clk);
    href = 1'b1; cam_d = 8'hAA; vsync = 1'b1;
    @(negedge clk) cam_d = 8'hBB;
    @(negedge clk) href = 1'b0;
    idle(4);
    total++;
    if (pix_data_q.size() !== 0 || fd_cnt !== 1 || err_odd !== 1'b0 || capturing !== 1'b0) begin
      bad++;
      $display("FAIL midline got n=%0d fd=%0d eo=%b cap=%b want 0 1 0 0",
               pix_data_q.size(), fd_cnt, err_odd, capturing);
    end
  endtask

  task automatic test_done_with_pixel();
    clear_mon();
    vs_low();
    @(negedge clk);
    href = 1'b1; cam_d = 8'hC1;
    @(negedge clk);
    cam_d = 8'hC2; vsync = 1'b1;
    @(negedge clk) href = 1'b0;
    idle(4);
    total++;
    if (pix_data_q.size() !== 1 || fd_cnt !== 1) begin
      bad++;
      $display("FAIL coincide_count got n=%0d fd=%0d want 1 1", pix_data_q.size(), fd_cnt);
    end else begin
      total++;
      if (pix_data_q[0] !== 16'hC1C2 || pix_addr_q[0] !== 3'd0 || pix_cyc_q[0] !== fd_cyc) begin
        bad++;
        $display("FAIL coincide_pixel got data=%h addr=%0d pcyc=%0d fdcyc=%0d want c1c2@0 same cycle",
                 pix_data_q[0], pix_addr_q[0], pix_cyc_q[0], fd_cyc);
      end
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_full_frame();
    test_enable_gating();
    test_odd_line();
    test_overflow();
    test_vsync_mid_line();
    test_done_with_pixel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
